// File: rtl/nbody_pkg.sv
// nbody_pkg: shared widths, FP64 field layout and plot-streamer FSM states.
package nbody_pkg;

    localparam int BODIES          = 512;
    localparam int DATA_WIDTH      = 64;
    localparam int BODY_ADDR_WIDTH = $clog2(BODIES);

    // IEEE-754 binary64 field layout
    localparam int EXP_BIAS = 1023;
    localparam int EXP_W    = 11;
    localparam int MANT_W   = 52;

    // Signed screen-coordinate intermediate, wide enough that +-65535 plus a
    // half-screen offset never wraps.
    localparam int PIX_W   = 18;
    // Any unbiased exponent at or above this cannot land on a 16-bit screen.
    localparam int MAX_EXP = 16;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        EMIT,
        DONE
    } plot_state_t;

endpackage

// File: rtl/f64_to_pixel.sv
// f64_to_pixel: combinational FP64 -> signed 18-bit integer, truncated toward
// zero after scaling by 2^SCALE_SHIFT. o_offscreen flags Inf/NaN or a
// magnitude too large for any screen coordinate.
module f64_to_pixel
    import nbody_pkg::*;
#(
    parameter int SCALE_SHIFT = 0
) (
    input  logic [DATA_WIDTH-1:0]   i_word,
    output logic signed [PIX_W-1:0] o_value,
    output logic                    o_offscreen
);

    localparam logic signed [13:0] EXP_ADJ   = 14'(SCALE_SHIFT - EXP_BIAS);
    localparam logic signed [13:0] EXP_LIMIT = 14'(MAX_EXP);
    localparam logic signed [13:0] MANT_TOP  = 14'(MANT_W);

    logic                    w_sign;
    logic [EXP_W-1:0]        w_exp;
    logic [MANT_W-1:0]       w_mant;
    logic signed [13:0]      w_e;
    logic [5:0]              w_sh;
    logic [15:0]             w_mag;

    assign w_sign = i_word[DATA_WIDTH-1];
    assign w_exp  = i_word[DATA_WIDTH-2 -: EXP_W];
    assign w_mant = i_word[MANT_W-1:0];
    assign w_e    = $signed({3'b000, w_exp}) + EXP_ADJ;

    // Decode exponent, shift the implicit-one significand down to an integer, apply sign.
    always_comb begin
        w_sh        = '0;
        w_mag       = '0;
        o_offscreen = (w_exp == '1);
        // Zero and denormals (exp field 0) and any |v| < 1 collapse to magnitude 0.
        if (w_exp != '0 && !w_e[13]) begin
            if (w_e >= EXP_LIMIT) begin
                o_offscreen = 1'b1;
            end else begin
                w_sh  = 6'(MANT_TOP - w_e);
                w_mag = 16'({1'b1, w_mant} >> w_sh);
            end
        end
        o_value = w_sign ? -$signed({2'b00, w_mag}) : $signed({2'b00, w_mag});
    end

endmodule

// File: rtl/body_plot_streamer.sv
// body_plot_streamer: walks the x/y position RAMs once per start pulse, converts
// each body to a screen pixel, drops clipped bodies and streams the rest as
// valid/ready beats. Optional macro PLOT_CLIP_COUNT_EN adds a clip_count output.
module body_plot_streamer #(
    parameter int BODIES          = nbody_pkg::BODIES,
    parameter int DATA_WIDTH      = nbody_pkg::DATA_WIDTH,
    parameter int BODY_ADDR_WIDTH = $clog2(BODIES),
    parameter int SCREEN_W        = 640,
    parameter int SCREEN_H        = 480,
    parameter int SCALE_SHIFT     = 0,
    parameter int X_BITS          = $clog2(SCREEN_W),
    parameter int Y_BITS          = $clog2(SCREEN_H)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BODY_ADDR_WIDTH-1:0] num_bodies,
    output logic [BODY_ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0]      x_data,
    input  logic [DATA_WIDTH-1:0]      y_data,
    output logic                       px_valid,
    input  logic                       px_ready,
    output logic [X_BITS-1:0]          px_x,
    output logic [Y_BITS-1:0]          px_y,
    output logic [BODY_ADDR_WIDTH-1:0] px_body,
    output logic                       busy,
    output logic                       frame_done
`ifdef PLOT_CLIP_COUNT_EN
    ,
    output logic [BODY_ADDR_WIDTH:0]   clip_count
`endif
);

    import nbody_pkg::*;

    localparam logic signed [PIX_W-1:0] HALF_W = PIX_W'(SCREEN_W / 2);
    localparam logic signed [PIX_W-1:0] HALF_H = PIX_W'(SCREEN_H / 2);
    localparam logic signed [PIX_W-1:0] LIM_W  = PIX_W'(SCREEN_W);
    localparam logic signed [PIX_W-1:0] LIM_H  = PIX_W'(SCREEN_H);

    plot_state_t                r_state;
    plot_state_t                w_state_next;
    logic [BODY_ADDR_WIDTH-1:0] r_idx;
    logic [BODY_ADDR_WIDTH-1:0] r_num;
    logic [X_BITS-1:0]          r_px_x;
    logic [Y_BITS-1:0]          r_px_y;
    logic [BODY_ADDR_WIDTH-1:0] r_px_body;

    logic [DATA_WIDTH-1:0]      w_word [2];
    logic signed [PIX_W-1:0]    w_val  [2];
    logic                       w_off  [2];
    logic signed [PIX_W-1:0]    w_sx;
    logic signed [PIX_W-1:0]    w_sy;
    logic                       w_offscreen;
    logic                       w_last;

    assign w_word[0] = x_data;
    assign w_word[1] = y_data;

    // Index 0 converts x, index 1 converts y.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_conv
            f64_to_pixel #(
                .SCALE_SHIFT (SCALE_SHIFT)
            ) u_conv (
                .i_word      (w_word[gi]),
                .o_value     (w_val[gi]),
                .o_offscreen (w_off[gi])
            );
        end
    endgenerate

    // Screen y grows downward while simulation y grows upward, hence the subtraction.
    assign w_sx        = HALF_W + w_val[0];
    assign w_sy        = HALF_H - w_val[1];
    assign w_offscreen = w_off[0] | w_off[1]
                       | w_sx[PIX_W-1] | (w_sx >= LIM_W)
                       | w_sy[PIX_W-1] | (w_sy >= LIM_H);
    assign w_last      = (r_idx == r_num - 1'b1);

    // The RAM address simply follows the body index; it only moves between bodies.
    assign rd_addr    = r_idx;
    assign px_valid   = (r_state == EMIT);
    assign busy       = (r_state != IDLE);
    assign frame_done = (r_state == DONE);
    assign px_x       = r_px_x;
    assign px_y       = r_px_y;
    assign px_body    = r_px_body;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic: FETCH presents the address, WAIT sees RAM data and decides.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = (num_bodies == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                w_state_next = WAIT;
            end
            WAIT: begin
                if (!w_offscreen) begin
                    w_state_next = EMIT;
                end else begin
                    w_state_next = w_last ? DONE : FETCH;
                end
            end
            EMIT: begin
                if (px_ready) begin
                    w_state_next = w_last ? DONE : FETCH;
                end
            end
            DONE: begin
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Datapath: latch frame length, capture converted pixel, advance body index.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_num     <= '0;
            r_px_x    <= '0;
            r_px_y    <= '0;
            r_px_body <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx <= '0;
                        r_num <= num_bodies;
                    end
                end
                WAIT: begin
                    r_px_x    <= w_sx[X_BITS-1:0];
                    r_px_y    <= w_sy[Y_BITS-1:0];
                    r_px_body <= r_idx;
                    if (w_offscreen && !w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                EMIT: begin
                    if (px_ready && !w_last) begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef PLOT_CLIP_COUNT_EN
    logic [BODY_ADDR_WIDTH:0] r_clip_count;

    // Count clipped bodies for the current frame; value persists after the frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_clip_count <= '0;
        end else if (r_state == IDLE && start) begin
            r_clip_count <= '0;
        end else if (r_state == WAIT && w_offscreen) begin
            r_clip_count <= r_clip_count + 1'b1;
        end
    end

    assign clip_count = r_clip_count;
`endif

endmodule

// File: tb/tb_body_plot_streamer.sv
// tb_body_plot_streamer: randomized and directed frames against a real-arithmetic
// reference model of the pixel conversion and clipping rules.
`timescale 1ns/1ps
module tb_body_plot_streamer;

    localparam int BAW = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [BAW-1:0]  num_bodies;
    logic [BAW-1:0]  rd_addr;
    logic [63:0]     x_data;
    logic [63:0]     y_data;
    logic            px_valid;
    logic            px_ready;
    logic [9:0]      px_x;
    logic [8:0]      px_y;
    logic [BAW-1:0]  px_body;
    logic            busy;
    logic            frame_done;
`ifdef PLOT_CLIP_COUNT_EN
    logic [BAW:0]    clip_count;
`endif

    body_plot_streamer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_bodies (num_bodies),
        .rd_addr    (rd_addr),
        .x_data     (x_data),
        .y_data     (y_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_body    (px_body),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef PLOT_CLIP_COUNT_EN
        ,
        .clip_count (clip_count)
`endif
    );

    always #5 clk = ~clk;

    // Position RAMs with one-cycle registered read.
    logic [63:0] xram [512];
    logic [63:0] yram [512];
    always @(posedge clk) begin
        x_data <= xram[rd_addr];
        y_data <= yram[rd_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] got_q [$];
    logic [31:0] exp_q [$];
    int          exp_clip;
    int          done_cnt;
    int          done_cyc;
    int          first_valid_cyc;
    int          stall_viol;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] pack(input int x, input int y, input int b);
        return {4'b0000, b[8:0], y[8:0], x[9:0]};
    endfunction

    // Reference conversion: real-valued truncation and range checks.
    function automatic bit to_screen(input logic [63:0] w, input bit is_y, output int pos);
        real v;
        int  iv;
        pos = 0;
        if (w[62:52] == 11'h7FF) return 1'b0;
        v = $bitstoreal(w);
        if (v >= 65536.0 || v <= -65536.0) return 1'b0;
        iv  = $rtoi(v);
        pos = is_y ? 240 - iv : 320 + iv;
        return (pos >= 0) && (pos < (is_y ? 480 : 640));
    endfunction

    task automatic build_expected(input int n);
        int sx;
        int sy;
        bit okx;
        bit oky;
        exp_q.delete();
        exp_clip = 0;
        for (int i = 0; i < n; i++) begin
            okx = to_screen(xram[i], 1'b0, sx);
            oky = to_screen(yram[i], 1'b1, sy);
            if (okx && oky) exp_q.push_back(pack(sx, sy, i));
            else            exp_clip++;
        end
    endtask

    function automatic logic [63:0] rand_coord(input int span);
        int  sel;
        real v;
        logic [63:0] bits;
        sel = int'($urandom_range(0, 11));
        case (sel)
            0: v = 1.0e6;
            1: v = -70000.5;
            2: begin bits = 64'hFFF0000000000000; return bits; end
            3: begin bits = 64'h0000000000000123; return bits; end
            default: v = real'(int'($urandom_range(0, 2 * span * 100)) - span * 100) / 100.0;
        endcase
        return $realtobits(v);
    endfunction

    // Monitor: record accepted beats, frame_done pulses and stall stability.
    initial begin
        bit          prev_stall = 1'b0;
        logic [31:0] prev_beat  = '0;
        logic [BAW-1:0] prev_addr = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall && (!px_valid || pack(px_x, px_y, px_body) != prev_beat
                                   || rd_addr != prev_addr))
                    stall_viol++;
                if (px_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
                if (px_valid && px_ready) begin
                    got_q.push_back(pack(px_x, px_y, px_body));
                    $display("beat body=%0d x=%0d y=%0d", px_body, px_x, px_y);
                end
                if (frame_done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = px_valid && !px_ready;
                prev_beat  = pack(px_x, px_y, px_body);
                prev_addr  = rd_addr;
            end
        end
    end

    // mode 0: ready always high; 1: random ready; 3: ready low 14 cycles plus a
    // second start (with a different num_bodies) while busy.
    task automatic run_frame(input int n, input int mode, input string tag);
        int t0;
        got_q.delete();
        done_cnt        = 0;
        done_cyc        = -1;
        first_valid_cyc = -1;
        stall_viol      = 0;
        build_expected(n);
        @(posedge clk); #1;
        num_bodies = BAW'(n);
        start      = 1'b1;
        px_ready   = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        t0         = cyc;
        for (int k = 0; k < 4000 && done_cnt == 0; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (mode == 3 && k == 1) begin
                start      = 1'b1;
                num_bodies = 9'd1;
            end
            case (mode)
                0:       px_ready = 1'b1;
                1:       px_ready = ($urandom_range(0, 3) != 0);
                default: px_ready = (k >= 14);
            endcase
        end
        px_ready = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        $display("frame %s bodies=%0d beats=%0d", tag, n, got_q.size());
        check_eq({tag, "_done_cnt"}, done_cnt, 1);
        check_eq({tag, "_beats"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq({tag, "_beat"}, got_q[i], exp_q[i]);
        check_eq({tag, "_stall"}, stall_viol, 0);
        check_eq({tag, "_idle"}, busy, 1'b0);
        if (n == 0)
            check_eq({tag, "_done_lat"}, done_cyc - t0, 1);
        if (mode == 0 && exp_q.size() > 0 && exp_q[0][27:19] == 9'd0)
            check_eq({tag, "_first_lat"}, first_valid_cyc - t0, 3);
`ifdef PLOT_CLIP_COUNT_EN
        check_eq({tag, "_clip"}, clip_count, exp_clip);
`endif
    endtask

    initial begin
        real bx [11];
        real by [11];
        bit  seen;
        int  n;

        rst        = 1'b1;
        start      = 1'b0;
        num_bodies = '0;
        px_ready   = 1'b0;
        done_cnt   = 0;
        stall_viol = 0;
        first_valid_cyc = -1;
        for (int i = 0; i < 512; i++) begin
            xram[i] = '0;
            yram[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_valid", px_valid, 1'b0);
        check_eq("rst_done", frame_done, 1'b0);
        check_eq("rst_addr", rd_addr, 0);
        check_eq("rst_px_x", px_x, 0);
        check_eq("rst_px_y", px_y, 0);
        check_eq("rst_px_body", px_body, 0);

        // Single body at (10.5, -3.0).
        xram[0] = 64'h4025000000000000;
        yram[0] = 64'hC008000000000000;
        run_frame(1, 0, "t1");
        check_eq("t1_pixel", (got_q.size() > 0) ? got_q[0] : 32'hFFFFFFFF, pack(330, 243, 0));

        // Three bodies; the middle one is off-screen.
        xram[0] = $realtobits(0.0);
        xram[1] = $realtobits(400.0);
        xram[2] = $realtobits(-0.75);
        yram[0] = '0; yram[1] = '0; yram[2] = '0;
        run_frame(3, 0, "t2");
        check_eq("t2_pixel0", (got_q.size() > 0) ? got_q[0] : 32'hFFFFFFFF, pack(320, 240, 0));
        check_eq("t2_pixel1", (got_q.size() > 1) ? got_q[1] : 32'hFFFFFFFF, pack(320, 240, 2));

        // Long stall in EMIT and an ignored start while busy.
        run_frame(3, 3, "t4");

        // NaN body produces no beat.
        xram[0] = 64'h7FF8000000000000;
        yram[0] = '0;
        run_frame(1, 0, "t3");

        // Empty frame.
        run_frame(0, 0, "t5");

        // Clipping boundaries, truncation toward zero, denormal, negative zero.
        bx = '{319.0, 320.0, -320.5, -321.0, 0.0, 0.0, 0.0, 0.0, 65535.0, 0.0, 0.0};
        by = '{0.0, 0.0, 0.0, 0.0, 240.5, 241.0, -239.9, -240.0, 0.0, -0.0, 0.0};
        for (int i = 0; i < 11; i++) begin
            xram[i] = $realtobits(bx[i]);
            yram[i] = $realtobits(by[i]);
        end
        xram[10] = 64'h000FFFFFFFFFFFFF;
        run_frame(11, 1, "bound");

        // Reset while a beat is stalled in EMIT.
        xram[0] = 64'h4025000000000000;
        yram[0] = 64'hC008000000000000;
        @(posedge clk); #1;
        num_bodies = 9'd1;
        start      = 1'b1;
        px_ready   = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (px_valid) seen = 1'b1;
        end
        check_eq("t6_emit", seen, 1'b1);
        @(posedge clk); #1;
        rst      = 1'b1;
        done_cnt = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("t6_valid", px_valid, 1'b0);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_done", frame_done, 1'b0);
        px_ready = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("t6_no_done", done_cnt, 0);

        // Randomized frames.
        for (int f = 0; f < 16; f++) begin
            n = int'($urandom_range(1, 30));
            for (int i = 0; i < n; i++) begin
                xram[i] = rand_coord(400);
                yram[i] = rand_coord(300);
            end
            run_frame(n, f % 2, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
